// File: rtl/exu_trap_pkg.sv
// Shared types and constants for the execute-stage trap controller:
// FSM state encoding, mcause codes and interrupt bit positions.
package exu_trap_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FLUSH = 2'd1,
        ST_VEC   = 2'd2,
        ST_RET   = 2'd3
    } state_e;

    localparam logic [31:0] CAUSE_MEI     = 32'h8000_000B;
    localparam logic [31:0] CAUSE_MSI     = 32'h8000_0003;
    localparam logic [31:0] CAUSE_MTI     = 32'h8000_0007;
    localparam logic [31:0] CAUSE_ILLEGAL = 32'h0000_0002;
    localparam logic [31:0] CAUSE_EBREAK  = 32'h0000_0003;
    localparam logic [31:0] CAUSE_ECALL   = 32'h0000_000B;

    // Bit positions inside irq_pend / irq_en ({meip,mtip,msip})
    localparam int IRQ_MSI = 0;
    localparam int IRQ_MTI = 1;
    localparam int IRQ_MEI = 2;

endpackage

// File: rtl/exu_trap_arb.sv
// Combinational priority encoder: decides whether the committing instruction
// takes an interrupt, an exception or an mret, and produces the matching cause.
module exu_trap_arb
    import exu_trap_pkg::*;
(
    input  logic        cmt_valid,
    input  logic        cmt_ecall,
    input  logic        cmt_ebreak,
    input  logic        cmt_illegal,
    input  logic        cmt_mret,
    input  logic [2:0]  irq_pend,
    input  logic [2:0]  irq_en,
    input  logic        status_mie,
    output logic        irq_take,
    output logic        exc_take,
    output logic        mret_take,
    output logic [31:0] cause
);

    logic [2:0] irq_hit;

    assign irq_hit   = irq_pend & irq_en;
    assign irq_take  = cmt_valid & status_mie & (|irq_hit);
    assign exc_take  = cmt_valid & (cmt_illegal | cmt_ebreak | cmt_ecall);
    assign mret_take = cmt_valid & cmt_mret;

    // Interrupts outrank exceptions; within interrupts MEI > MSI > MTI
    always_comb begin
        cause = 32'h0;
        if (irq_take) begin
            if (irq_hit[IRQ_MEI])      cause = CAUSE_MEI;
            else if (irq_hit[IRQ_MSI]) cause = CAUSE_MSI;
            else                       cause = CAUSE_MTI;
        end else if (cmt_valid) begin
            if (cmt_illegal)      cause = CAUSE_ILLEGAL;
            else if (cmt_ebreak)  cause = CAUSE_EBREAK;
            else if (cmt_ecall)   cause = CAUSE_ECALL;
        end
    end

endmodule

// File: rtl/exu_trap.sv
// Trap/return sequencer: captures a trap or mret at commit, drains the
// pipeline through a flush handshake, then redirects fetch and updates CSRs.
module exu_trap
    import exu_trap_pkg::*;
#(
    parameter int VEC_EN = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmt_valid,
    output logic        cmt_ready,
    input  logic [31:0] cmt_pc,
    input  logic        cmt_ecall,
    input  logic        cmt_ebreak,
    input  logic        cmt_illegal,
    input  logic        cmt_mret,
    input  logic [2:0]  irq_pend,
    input  logic [2:0]  irq_en,
    input  logic        status_mie,
    input  logic [31:0] mtvec,
    input  logic [31:0] cmepc,
    output logic        flush_req,
    input  logic        flush_ack,
    output logic        redir_valid,
    output logic [31:0] redir_pc,
    output logic        trap_ena,
    output logic        mret_ena,
    output logic        epc_en,
    output logic        in_retr,
    output logic [31:0] epc_pc,
    output logic [31:0] mcause
);

    state_e      state, state_nxt;
    logic        irq_take, exc_take, mret_take;
    logic [31:0] arb_cause;
    logic        hs, capture;

    logic [31:0] epc_p1, cause_p1, target_p1;
    logic        mret_p1;

    // Vectored mode only applies to interrupts and only with mtvec.MODE == 1
    function automatic logic [31:0] trap_target(input logic [31:0] tvec,
                                                input logic [3:0]  code,
                                                input logic        is_irq);
        logic [31:0] base;
        base = {tvec[31:2], 2'b00};
        if ((VEC_EN != 0) && (tvec[1:0] == 2'b01) && is_irq)
            return base + {26'd0, code, 2'b00};
        return base;
    endfunction

    exu_trap_arb u_arb (
        .cmt_valid   (cmt_valid),
        .cmt_ecall   (cmt_ecall),
        .cmt_ebreak  (cmt_ebreak),
        .cmt_illegal (cmt_illegal),
        .cmt_mret    (cmt_mret),
        .irq_pend    (irq_pend),
        .irq_en      (irq_en),
        .status_mie  (status_mie),
        .irq_take    (irq_take),
        .exc_take    (exc_take),
        .mret_take   (mret_take),
        .cause       (arb_cause)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            epc_p1    <= 32'h0;
            cause_p1  <= 32'h0;
            target_p1 <= 32'h0;
            mret_p1   <= 1'b0;
            mcause    <= 32'h0;
        end else begin
            state <= state_nxt;
            if (capture) begin
                epc_p1    <= cmt_pc;
                cause_p1  <= arb_cause;
                target_p1 <= trap_target(mtvec, arb_cause[3:0], irq_take);
                mret_p1   <= ~irq_take & ~exc_take;
            end
            if (state == ST_VEC)
                mcause <= cause_p1;
        end
    end

    always_comb begin
        state_nxt   = state;
        cmt_ready   = 1'b0;
        hs          = 1'b0;
        in_retr     = 1'b0;
        capture     = 1'b0;
        flush_req   = 1'b0;
        trap_ena    = 1'b0;
        epc_en      = 1'b0;
        mret_ena    = 1'b0;
        redir_valid = 1'b0;
        epc_pc      = 32'h0;
        redir_pc    = 32'h0;
        case (state)
            ST_IDLE: begin
                // An interrupt steals the commit slot: the instruction is not accepted
                cmt_ready = ~irq_take & ~rst;
                hs        = cmt_valid & cmt_ready;
                in_retr   = hs & ~exc_take;
                capture   = ~rst & (irq_take | (hs & (exc_take | mret_take)));
                if (capture)
                    state_nxt = ST_FLUSH;
            end
            ST_FLUSH: begin
                flush_req = 1'b1;
                if (flush_ack)
                    state_nxt = mret_p1 ? ST_RET : ST_VEC;
            end
            ST_VEC: begin
                trap_ena    = 1'b1;
                epc_en      = 1'b1;
                redir_valid = 1'b1;
                epc_pc      = epc_p1;
                redir_pc    = target_p1;
                state_nxt   = ST_IDLE;
            end
            ST_RET: begin
                mret_ena    = 1'b1;
                redir_valid = 1'b1;
                redir_pc    = cmepc;
                state_nxt   = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_exu_trap.sv
// Directed + randomized bench for exu_trap; expected values come from a
// priority-table reference model of the trap rules.
module tb_exu_trap;

    localparam int VEC_EN_TB = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmt_valid;
    logic        cmt_ready;
    logic [31:0] cmt_pc;
    logic        cmt_ecall, cmt_ebreak, cmt_illegal, cmt_mret;
    logic [2:0]  irq_pend, irq_en;
    logic        status_mie;
    logic [31:0] mtvec, cmepc;
    logic        flush_req, flush_ack;
    logic        redir_valid;
    logic [31:0] redir_pc;
    logic        trap_ena, mret_ena, epc_en, in_retr;
    logic [31:0] epc_pc, mcause;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] exp_mcause = 32'h0;

    exu_trap #(.VEC_EN(VEC_EN_TB)) dut (
        .clk         (clk),
        .rst         (rst),
        .cmt_valid   (cmt_valid),
        .cmt_ready   (cmt_ready),
        .cmt_pc      (cmt_pc),
        .cmt_ecall   (cmt_ecall),
        .cmt_ebreak  (cmt_ebreak),
        .cmt_illegal (cmt_illegal),
        .cmt_mret    (cmt_mret),
        .irq_pend    (irq_pend),
        .irq_en      (irq_en),
        .status_mie  (status_mie),
        .mtvec       (mtvec),
        .cmepc       (cmepc),
        .flush_req   (flush_req),
        .flush_ack   (flush_ack),
        .redir_valid (redir_valid),
        .redir_pc    (redir_pc),
        .trap_ena    (trap_ena),
        .mret_ena    (mret_ena),
        .epc_en      (epc_en),
        .in_retr     (in_retr),
        .epc_pc      (epc_pc),
        .mcause      (mcause)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Reference priority tables: interrupts scanned MEI, MSI, MTI; then illegal, ebreak, ecall
    function automatic logic [31:0] model_cause(input logic irq, input logic [2:0] hit,
                                                input logic ill, input logic ebr, input logic ecl);
        int          irq_bit  [3] = '{2, 0, 1};
        logic [31:0] irq_code [3] = '{32'h8000000B, 32'h80000003, 32'h80000007};
        logic        exc_flag [3];
        logic [31:0] exc_code [3] = '{32'h2, 32'h3, 32'hB};
        exc_flag = '{ill, ebr, ecl};
        if (irq) begin
            for (int i = 0; i < 3; i++)
                if (hit[irq_bit[i]]) return irq_code[i];
        end
        for (int i = 0; i < 3; i++)
            if (exc_flag[i]) return exc_code[i];
        return 32'h0;
    endfunction

    task automatic clear_cmt();
        cmt_valid = 1'b0; cmt_ecall = 1'b0; cmt_ebreak = 1'b0;
        cmt_illegal = 1'b0; cmt_mret = 1'b0;
    endtask

    task automatic txn(input string tag, input logic [31:0] pc,
                       input logic ill, input logic ebr, input logic ecl, input logic mrt,
                       input logic [2:0] pend, input logic [2:0] en, input logic mie,
                       input logic [31:0] tvec, input logic [31:0] mepc, input int ack_dly);
        logic        irq, exc, is_trap, is_ret, vect;
        logic [31:0] ecause, etgt;
        irq     = mie && ((pend & en) != 3'b000);
        exc     = ill | ebr | ecl;
        ecause  = model_cause(irq, pend & en, ill, ebr, ecl);
        is_trap = irq | exc;
        is_ret  = !is_trap && mrt;
        vect    = (VEC_EN_TB != 0) && (tvec % 4 == 1) && irq;
        etgt    = (tvec & 32'hFFFF_FFFC) + (vect ? ((ecause & 32'hF) * 4) : 32'h0);

        @(posedge clk); #1;
        cmt_valid = 1'b1; cmt_pc = pc; cmt_illegal = ill; cmt_ebreak = ebr;
        cmt_ecall = ecl; cmt_mret = mrt; irq_pend = pend; irq_en = en;
        status_mie = mie; mtvec = tvec; cmepc = mepc;
        #3;
        chk1({tag, ".cmt_ready"}, cmt_ready, !irq);
        chk1({tag, ".in_retr"}, in_retr, !irq && !exc);
        chk1({tag, ".idle_flush"}, flush_req, 1'b0);

        @(posedge clk); #1;
        clear_cmt();
        // Interrupt inputs wander while the event is in flight; the capture must not change
        irq_pend = 3'($urandom); irq_en = 3'($urandom); status_mie = 1'($urandom);
        mtvec = $urandom;
        if (!is_trap && !is_ret) begin
            #3;
            chk1({tag, ".no_flush"}, flush_req, 1'b0);
            return;
        end
        repeat (ack_dly) begin
            #3;
            chk1({tag, ".flush_hold"}, flush_req, 1'b1);
            chk1({tag, ".flush_no_redir"}, redir_valid, 1'b0);
            chk1({tag, ".flush_no_trap"}, trap_ena, 1'b0);
            @(posedge clk); #1;
        end
        flush_ack = 1'b1;
        #3;
        chk1({tag, ".flush_req"}, flush_req, 1'b1);
        @(posedge clk); #1;
        flush_ack = 1'b0;
        #3;
        chk1({tag, ".post_flush_req"}, flush_req, 1'b0);
        chk1({tag, ".redir_valid"}, redir_valid, 1'b1);
        chk1({tag, ".trap_ena"}, trap_ena, is_trap);
        chk1({tag, ".epc_en"}, epc_en, is_trap);
        chk1({tag, ".mret_ena"}, mret_ena, is_ret);
        chk32({tag, ".epc_pc"}, epc_pc, is_trap ? pc : 32'h0);
        chk32({tag, ".redir_pc"}, redir_pc, is_trap ? etgt : mepc);
        chk32({tag, ".mcause_before"}, mcause, exp_mcause);
        @(posedge clk); #1;
        if (is_trap) exp_mcause = ecause;
        #3;
        chk32({tag, ".mcause"}, mcause, exp_mcause);
        chk1({tag, ".back_idle_redir"}, redir_valid, 1'b0);
        chk1({tag, ".back_idle_trap"}, trap_ena, 1'b0);
        chk1({tag, ".back_idle_ready"}, cmt_ready, 1'b1);
    endtask

    initial begin
        rst = 1'b1; clear_cmt(); cmt_pc = 32'h0; irq_pend = 3'b000; irq_en = 3'b000;
        status_mie = 1'b0; mtvec = 32'h0; cmepc = 32'h0; flush_ack = 1'b0;

        // Reset state; a commit presented during reset is neither retired nor trapped
        repeat (2) @(posedge clk);
        #1; cmt_valid = 1'b1; cmt_ecall = 1'b1; cmt_pc = 32'h300;
        #3;
        chk1("rst.in_retr", in_retr, 1'b0);
        chk1("rst.cmt_ready", cmt_ready, 1'b0);
        chk1("rst.flush_req", flush_req, 1'b0);
        chk1("rst.trap_ena", trap_ena, 1'b0);
        chk1("rst.redir_valid", redir_valid, 1'b0);
        chk32("rst.mcause", mcause, 32'h0);
        chk32("rst.epc_pc", epc_pc, 32'h0);
        chk32("rst.redir_pc", redir_pc, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0; clear_cmt();
        #3;
        chk1("rst_rel.flush_req", flush_req, 1'b0);
        chk1("rst_rel.cmt_ready", cmt_ready, 1'b1);

        txn("ecall", 32'h100, 0, 0, 1, 0, 3'b000, 3'b000, 0, 32'h201, 32'h0, 2);
        txn("mei",   32'h40,  0, 0, 0, 0, 3'b100, 3'b100, 1, 32'h201, 32'h0, 1);
        txn("mret",  32'h60,  0, 0, 0, 1, 3'b000, 3'b000, 0, 32'h201, 32'h80, 0);
        txn("ill_ecall_masked", 32'h44, 1, 0, 1, 0, 3'b001, 3'b001, 0, 32'h200, 32'h0, 0);
        txn("ebreak", 32'h48, 0, 1, 0, 1, 3'b000, 3'b111, 1, 32'h301, 32'h0, 0);
        txn("msi_vs_mti", 32'h4C, 1, 0, 0, 0, 3'b011, 3'b011, 1, 32'h1001, 32'h0, 0);
        txn("stall10", 32'h50, 0, 0, 1, 0, 3'b000, 3'b000, 0, 32'h400, 32'h0, 10);

        // Reset while in FLUSH drops the trap entirely
        @(posedge clk); #1;
        cmt_valid = 1'b1; cmt_ecall = 1'b1; cmt_pc = 32'h500; mtvec = 32'h400;
        irq_en = 3'b000;
        @(posedge clk); #1;
        clear_cmt();
        #3;
        chk1("rstflush.in_flush", flush_req, 1'b1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; flush_ack = 1'b1; exp_mcause = 32'h0;
        #3;
        chk1("rstflush.flush_req", flush_req, 1'b0);
        chk1("rstflush.trap_ena", trap_ena, 1'b0);
        chk32("rstflush.mcause", mcause, 32'h0);
        @(posedge clk); #1;
        flush_ack = 1'b0;
        #3;
        chk1("rstflush.trap_ena_after", trap_ena, 1'b0);
        chk1("rstflush.redir_after", redir_valid, 1'b0);

        // Back-to-back plain commits retire one per cycle
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            cmt_valid = 1'b1; cmt_pc = $urandom; irq_pend = 3'($urandom);
            irq_en = 3'b000; status_mie = 1'($urandom);
            #3;
            chk1("stream.in_retr", in_retr, 1'b1);
            chk1("stream.cmt_ready", cmt_ready, 1'b1);
            chk1("stream.flush_req", flush_req, 1'b0);
        end
        @(posedge clk); #1;
        clear_cmt();

        for (int i = 0; i < 40; i++) begin
            logic [31:0] tv;
            tv = {$urandom} & 32'hFFFF_FFFC;
            tv[0] = 1'($urandom);
            txn("rand", $urandom,
                ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0),
                3'($urandom), 3'($urandom), 1'($urandom), tv, $urandom,
                $urandom_range(0, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
